// File: rtl/aes_encrypt_iter.sv
// Iterative AES encrypt: one round per clock, AES-128/192/256 via nk/nr.
// Define AES_ENC_ROUND_DBG_EN to add the dbg_round/dbg_state ports.
module aes_encrypt_iter #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [0:127]             in,
  input  logic [0:128*(nr+1)-1]    key,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:127]             out
`ifdef AES_ENC_ROUND_DBG_EN
  ,
  output logic [0:3]               dbg_round,
  output logic [0:127]             dbg_state
`endif
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [3:0] LAST = 4'(nr);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t         fsm, fsm_nx;
  logic [3:0]   round, round_nx;
  logic [0:127] st, st_nx, out_nx;
  logic [0:127] sb, sr, mc, rk_cur;
  logic [0:127] rk [0:nr];

  if (nr != nk + 6) begin : g_bad_cfg
    $error("aes_encrypt_iter: nr must equal nk+6");
  end

  for (genvar g = 0; g <= nr; g++) begin : g_rk
    assign rk[g] = key[128*g +: 128];
  end
  assign rk_cur = rk[round];

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*b +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_comb begin
    sb = '0;
    for (int k = 0; k < 16; k++)
      sb[8*k +: 8] = sbox(st[8*k +: 8]);
  end

  // row r of the column-major block rotates left by r columns
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[8*(r+4*c) +: 8] = sb[8*(r+4*((c+r)%4)) +: 8];
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[32*c +: 32] = mixcol(sr[32*c +: 32]);
  end

  always_comb begin
    fsm_nx    = fsm;
    round_nx  = round;
    st_nx     = st;
    out_nx    = out;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (fsm)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          st_nx    = in ^ rk[0];
          round_nx = 4'd1;
          fsm_nx   = ROUND;
        end
      end
      ROUND: begin
        if (round == LAST) begin
          st_nx  = sr ^ rk_cur;
          out_nx = sr ^ rk_cur;
          fsm_nx = DONE;
        end else begin
          st_nx    = mc ^ rk_cur;
          round_nx = round + 4'd1;
        end
      end
      DONE: begin
        out_valid = !rst;
        if (out_ready) fsm_nx = IDLE;
      end
      default: fsm_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      round <= '0;
      st    <= '0;
      out   <= '0;
    end else begin
      fsm   <= fsm_nx;
      round <= round_nx;
      st    <= st_nx;
      out   <= out_nx;
    end
  end

`ifdef AES_ENC_ROUND_DBG_EN
  assign dbg_round = round;
  assign dbg_state = st;
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors plus random blocks
// checked cycle by cycle against a byte-level AES model.
module tb_aes_encrypt_iter;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [0:127]       din = '0, dout;
  logic [0:128*11-1]  key = '0;

  logic               v_x = 1'b0, r12, r14, ov12, ov14;
  logic [0:127]       pt_x = '0, o12, o14;
  logic [0:128*13-1]  key12 = '0;
  logic [0:128*15-1]  key14 = '0;

  aes_encrypt_iter #(.nk(4), .nr(10)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(din), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout));

  aes_encrypt_iter #(.nk(6), .nr(12)) u_d12 (
    .clk(clk), .rst(rst), .in_valid(v_x), .in_ready(r12),
    .in(pt_x), .key(key12), .out_valid(ov12), .out_ready(1'b1),
    .out(o12));

  aes_encrypt_iter #(.nk(8), .nr(14)) u_d14 (
    .clk(clk), .rst(rst), .in_valid(v_x), .in_ready(r14),
    .in(pt_x), .key(key14), .out_valid(ov14), .out_ready(1'b1),
    .out(o14));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
    return v;
  endfunction

  function automatic logic [7:0] sb_m(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  function automatic logic [0:128*15-1] expand(input logic [0:255] k,
                                               input int nk, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [0:128*15-1] s = '0;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  function automatic logic [0:127] enc(input logic [0:127] p,
                                       input logic [0:128*15-1] s, input int nr);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] x0, x1, x2, x3;
    logic [0:127] o;
    for (int k = 0; k < 16; k++) a[k] = p[8*k +: 8] ^ s[8*k +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) b[k] = sbt[a[k]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          a[row+4*col] = b[row+4*((col+row)%4)];
      if (r < nr) begin
        for (int col = 0; col < 4; col++) begin
          x0 = a[4*col]; x1 = a[4*col+1]; x2 = a[4*col+2]; x3 = a[4*col+3];
          a[4*col]   = gmul(2, x0) ^ gmul(3, x1) ^ x2 ^ x3;
          a[4*col+1] = x0 ^ gmul(2, x1) ^ gmul(3, x2) ^ x3;
          a[4*col+2] = x0 ^ x1 ^ gmul(2, x2) ^ gmul(3, x3);
          a[4*col+3] = gmul(3, x0) ^ x1 ^ x2 ^ gmul(2, x3);
        end
      end
      for (int k = 0; k < 16; k++) a[k] ^= s[128*r + 8*k +: 8];
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = a[k];
    return o;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- cycle monitor / scoreboard ----------------
  bit            mon_en = 1'b0;
  int            busy = 0, since = 0, cyc = 0, acc_cyc = 0;
  bit            prev_ov = 1'b0;
  logic [0:127]  q [$];
  logic [0:127]  got [$];
  logic [0:127]  last_out = '0;
  int            deliv [$];
  int            lats [$];
  logic [0:128*15-1] s15;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (rst) begin
        chk("rst_in_ready", in_ready, 1'b0);
        q.delete();
        busy = 0;
        last_out = '0;
        prev_ov = 1'b0;
      end else begin
        if (busy != 0) since++;
        chk("out_valid", out_valid, busy != 0 && since >= NR + 1);
        chk("in_ready", in_ready, busy == 0);
        if (out_valid && q.size() > 0) chk("out_data", dout, q[0]);
        else chk("out_hold", dout, last_out);
        if (out_valid && !prev_ov) lats.push_back(cyc - acc_cyc);
        prev_ov = out_valid;
        if (out_valid && out_ready && q.size() > 0) begin
          last_out = q.pop_front();
          got.push_back(dout);
          deliv.push_back(cyc);
          busy = 0;
        end
        if (in_valid && in_ready) begin
          s15 = '0;
          s15[0:128*11-1] = key;
          q.push_back(enc(din, s15, NR));
          busy = 1;
          since = 0;
          acc_cyc = cyc;
        end
      end
    end
  end

  bit rnd_rdy = 1'b0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom % 2);
  end

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [0:127] p, input logic [0:255] k);
    logic [0:128*15-1] s;
    int n = 0;
    s = expand(k, 4, NR);
    key = s[0:128*11-1];
    din = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done", busy, 0);
  endtask

  task automatic garbage();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (busy == 0) break;
      in_valid = 1'($urandom % 2);
      din = rnd128();
    end
    in_valid = 1'b0;
  endtask

  localparam logic [0:127] PT_A = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:255] K_A  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:127] CT_A = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT_C = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] K_C  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:127] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [0:128*15-1] s;
    logic [0:127] e12, e14, g12, g14;
    int n, n0, l12, l14;

    for (int x = 0; x < 256; x++) sbt[x] = sb_m(8'(x));

    // reset
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out", dout, 128'h0);
    rst = 1'b0;

    // model pins
    chk("model_sbox00", sbt[0], 8'h63);
    chk("model_sbox53", sbt[8'h53], 8'hed);
    s = expand(K_A, 4, 10);
    chk("model_rk10", s[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_aes128", enc(PT_A, s, 10), CT_A);
    s = expand(K_C, 4, 10);
    chk("model_c1", enc(PT_C, s, 10), CT_C);

    // AES-192 / AES-256
    s = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    key12 = s[0:128*13-1];
    e12 = enc(PT_C, s, 12);
    chk("model_aes192", e12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    s = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    key14 = s;
    e14 = enc(PT_C, s, 14);
    chk("model_aes256", e14, 128'h8ea2b7ca516745bfeafc49904b496089);
    @(posedge clk);
    #1;
    pt_x = PT_C;
    v_x = 1'b1;
    @(negedge clk);
    chk("in_ready_192", r12, 1'b1);
    chk("in_ready_256", r14, 1'b1);
    n = 0; l12 = 0; l14 = 0; g12 = '0; g14 = '0;
    while ((l12 == 0 || l14 == 0) && n < 60) begin
      @(negedge clk);
      v_x = 1'b0;
      n++;
      if (ov12 && l12 == 0) begin l12 = n; g12 = o12; end
      if (ov14 && l14 == 0) begin l14 = n; g14 = o14; end
    end
    chk("lat_192", l12, 13);
    chk("lat_256", l14, 15);
    chk("out_192", g12, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("out_256", g14, 128'h8ea2b7ca516745bfeafc49904b496089);
    chk("out_192_model", g12, e12);
    chk("out_256_model", g14, e14);

    // AES-128 FIPS vector
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(PT_A, K_A);
    wait_done();
    chk("fips128", got[got.size()-1], CT_A);
    chk("lat128", lats[lats.size()-1], 11);

    // backpressure: hold out_ready low 20 cycles with in_valid noise
    out_ready = 1'b0;
    send(PT_C, K_C);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      din = rnd128();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    chk("bp_out", got[got.size()-1], CT_C);

    // reset at round 5
    n0 = deliv.size();
    send(PT_A, K_A);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_pulse", deliv.size(), n0);
    send(PT_A, K_A);
    wait_done();
    chk("abort_resend", got[got.size()-1], CT_A);

    // back-to-back with in_valid held high
    n0 = got.size();
    s = expand(K_C, 4, NR);
    key = s[0:128*11-1];
    din = PT_C;
    in_valid = 1'b1;
    n = 0;
    while (got.size() < n0 + 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    s = expand(K_A, 4, NR);
    key = s[0:128*11-1];
    din = PT_A;
    n = 0;
    while (got.size() < n0 + 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_count", got.size(), n0 + 2);
    if (got.size() >= n0 + 2) begin
      chk("b2b_first", got[n0], CT_C);
      chk("b2b_second", got[n0+1], CT_A);
      chk("b2b_spacing", deliv[n0+1] - deliv[n0], NR + 2);
    end

    // random blocks, random keys, random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(rnd128(), {rnd128(), 128'h0});
      garbage();
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
